// File: rtl/fft_input_buffer.sv
// fft_input_buffer: collects one N-point complex frame in natural time order,
// then streams it to the butterfly stage with a valid/ready handshake.
// Optional feature: define FFT_BITREV_EN to emit the frame in bit-reversed
// address order (decimation-in-time input); otherwise natural order is used.
module fft_input_buffer #(
    parameter int DW    = 16,
    parameter int LOG2N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_re,
    input  logic [DW-1:0]    in_im,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
    output logic             frame_err
);

    localparam int               N        = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_PTR = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [LOG2N-1:0] r_wr_ptr;
    logic [LOG2N-1:0] r_rd_ptr;
    logic [DW-1:0]    r_buf_re [N];
    logic [DW-1:0]    r_buf_im [N];
    logic             r_out_valid;
    logic [DW-1:0]    r_out_re;
    logic [DW-1:0]    r_out_im;
    logic [LOG2N-1:0] r_out_idx;
    logic             r_frame_err;
    logic             w_wr_en;
    logic             w_rd_fire;
    logic             w_wr_at_end;
    logic             w_rd_at_end;
    logic [LOG2N-1:0] w_rd_addr_next;

    // Maps the k-th output slot to the buffer address it presents.
    function automatic logic [LOG2N-1:0] map_addr(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] a;
`ifdef FFT_BITREV_EN
        for (int i = 0; i < LOG2N; i++) begin
            a[i] = k[LOG2N-1-i];
        end
`else
        a = k;
`endif
        return a;
    endfunction

    assign w_wr_at_end    = (r_wr_ptr == LAST_PTR);
    assign w_rd_at_end    = (r_rd_ptr == LAST_PTR);
    assign w_rd_addr_next = map_addr(r_rd_ptr + ONE);

    // Next-state and handshake decode; flush overrides every handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_wr_en      = 1'b0;
        w_rd_fire    = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                w_wr_en  = in_valid;
                if (in_valid && w_wr_at_end) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_rd_fire = r_out_valid && out_ready;
                if (w_rd_fire && w_rd_at_end) begin
                    w_state_next = S_FILL;
                end
            end
            default: w_state_next = S_FILL;
        endcase
        if (flush) begin
            w_state_next = S_FILL;
            w_wr_en      = 1'b0;
            w_rd_fire    = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) r_state <= S_FILL;
        else        r_state <= w_state_next;
    end

    // Sample storage: written in time order, only ever read after a full frame.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; nothing is read before it is written.
        if (w_wr_en) begin
            r_buf_re[r_wr_ptr] <= in_re;
            r_buf_im[r_wr_ptr] <= in_im;
        end
    end

    // Pointers and output register: load entry 0 on the fill-complete edge,
    // then advance one entry per accepted output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_idx   <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ONE;
                if (w_wr_at_end) begin
                    // Entry 0 is never the one being written on this edge.
                    r_out_re    <= r_buf_re[map_addr('0)];
                    r_out_im    <= r_buf_im[map_addr('0)];
                    r_out_idx   <= map_addr('0);
                    r_out_valid <= 1'b1;
                end
            end
            if (w_rd_fire) begin
                if (w_rd_at_end) begin
                    r_rd_ptr    <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_rd_ptr  <= r_rd_ptr + ONE;
                    r_out_re  <= r_buf_re[w_rd_addr_next];
                    r_out_im  <= r_buf_im[w_rd_addr_next];
                    r_out_idx <= w_rd_addr_next;
                end
            end
        end
    end

    // Sticky framing error: in_last must coincide exactly with the N-th write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else if (w_wr_en && (in_last != w_wr_at_end)) begin
            r_frame_err <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_valid && w_rd_at_end;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer: a frame model pushes the expected
// output sequence when the N-th sample is accepted; a negedge monitor pops
// and compares on each output handshake and checks stall stability.
module tb_fft_input_buffer;

    localparam int DW    = 16;
    localparam int LOG2N = 4;
    localparam int N     = 1 << LOG2N;

    typedef struct {
        logic [DW-1:0]    re;
        logic [DW-1:0]    im;
        logic [LOG2N-1:0] idx;
        logic             last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_re = '0;
    logic [DW-1:0]    in_im = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_re;
    logic [DW-1:0]    out_im;
    logic [LOG2N-1:0] out_idx;
    logic             out_last;
    logic             frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t          sb_q[$];
    logic [DW-1:0] m_re [N];
    logic [DW-1:0] m_im [N];
    int            m_wr  = 0;
    logic          m_err = 1'b0;
    bit            rand_ready = 1'b0;

    fft_input_buffer #(.DW(DW), .LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output order of the reference model.
    function automatic logic [LOG2N-1:0] slot_addr(input int k);
        logic [LOG2N-1:0] kk;
        logic [LOG2N-1:0] r;
        kk = LOG2N'(k);
`ifdef FFT_BITREV_EN
        r = '0;
        for (int i = 0; i < LOG2N; i++) r = {r[LOG2N-2:0], kk[i]};
`else
        r = kk;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_wr  = 0;
        m_err = 1'b0;
        sb_q.delete();
    endtask

    // Random 50% backpressure when enabled.
    always begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    end

    // Output monitor.
    exp_t          mon_e;
    bit            mon_stalled = 0;
    bit            mon_after_last = 0;
    logic [DW-1:0] h_re, h_im;
    logic [LOG2N-1:0] h_idx;
    logic          h_last;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mon_after_last) begin
                check("in_ready_after_last", in_ready, 1);
                check("out_valid_after_last", out_valid, 0);
                mon_after_last = 0;
            end
            if (out_valid) begin
                check("in_ready_in_drain", in_ready, 0);
                if (mon_stalled) begin
                    check("hold_re", out_re, h_re);
                    check("hold_im", out_im, h_im);
                    check("hold_idx", out_idx, h_idx);
                    check("hold_last", out_last, h_last);
                end
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 64'(sb_q.size()), 1);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("out_re", out_re, mon_e.re);
                        check("out_im", out_im, mon_e.im);
                        check("out_idx", out_idx, mon_e.idx);
                        check("out_last", out_last, mon_e.last);
                        if (mon_e.last) mon_after_last = 1;
                    end
                end
            end
            mon_stalled = out_valid && !out_ready;
            h_re = out_re; h_im = out_im; h_idx = out_idx; h_last = out_last;
        end else begin
            mon_stalled    = 0;
            mon_after_last = 0;
        end
    end

    task automatic wait_ready();
        int c;
        c = 0;
        while (!in_ready && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    // Drives n samples; in_last on sample last_at (-1 for none).
    task automatic send_frame(input int n, input int last_at, input bit rnd);
        logic [DW-1:0] re, im;
        int a;
        for (int k = 0; k < n; k++) begin
            re = rnd ? DW'($urandom) : DW'(k);
            im = rnd ? DW'($urandom) : DW'(-k);
            in_valid = 1'b1;
            in_re    = re;
            in_im    = im;
            in_last  = (k == last_at);
            wait_ready();
            if (m_wr == N - 1) check("first_valid_early", out_valid, 0);
            @(posedge clk);
            #1;
            if (in_last != (m_wr == N - 1)) m_err = 1'b1;
            m_re[m_wr] = re;
            m_im[m_wr] = im;
            if (m_wr == N - 1) begin
                for (int j = 0; j < N; j++) begin
                    a = int'(slot_addr(j));
                    sb_q.push_back('{re: m_re[a], im: m_im[a], idx: slot_addr(j), last: (j == N - 1)});
                end
                m_wr = 0;
                check("first_valid", out_valid, 1);
            end else begin
                m_wr++;
            end
            check("frame_err", frame_err, m_err);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((sb_q.size() != 0 || out_valid) && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_done", (sb_q.size() == 0) && !out_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_out_re"}, out_re, 0);
        check({tag, "_out_im"}, out_im, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        // Reset state.
        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Clean frame, continuous out_ready.
        out_ready = 1'b1;
        send_frame(N, N - 1, 1'b0);
        wait_drain();
        check("clean_frame_err", frame_err, 0);

        // Random backpressure.
        rand_ready = 1'b1;
        send_frame(N, N - 1, 1'b1);
        wait_drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Early in_last: sticky error, frame length unchanged.
        send_frame(N, 9, 1'b1);
        wait_drain();
        send_frame(N, N - 1, 1'b1);
        wait_drain();
        check("err_sticky", frame_err, 1);

        // Flush a partial frame, then a clean one.
        send_frame(7, -1, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        m_wr  = 0;
        check("flush_in_ready", in_ready, 1);
        send_frame(N, N - 1, 1'b1);
        wait_drain();

        // Flush while stalled in DRAIN.
        out_ready = 1'b0;
        send_frame(N, N - 1, 1'b1);
        @(posedge clk);
        #1;
        check("drain_stalled_valid", out_valid, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb_q.delete();
        check("flush_drain_valid", out_valid, 0);
        check("flush_drain_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_output", out_valid, 0);

        // Asynchronous reset mid-DRAIN.
        send_frame(N, N - 1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        send_frame(N, N - 1, 1'b0);
        wait_drain();
        check("final_frame_err", frame_err, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
